// File: rtl/dma_copy_ctrl.sv
// Chunked memory-to-memory copy controller: splits a byte range into master-sized
// chunks, kicks read and write masters together and streams words read->write buffer.
module dma_copy_ctrl #(
    parameter int ADDRESSWIDTH = 28,
    parameter int DATAWIDTH    = 32,
    parameter int CHUNK_BYTES  = 256
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic [ADDRESSWIDTH-1:0] src_addr,
    input  logic [ADDRESSWIDTH-1:0] dst_addr,
    input  logic [ADDRESSWIDTH-1:0] length,
    output logic                    busy,
    output logic                    done,
    output logic                    error,
    output logic [ADDRESSWIDTH-1:0] words_copied,
    output logic                    ctl_rd_fixed_location,
    output logic                    ctl_wr_fixed_location,
    output logic [ADDRESSWIDTH-1:0] ctl_rd_addr_base,
    output logic [ADDRESSWIDTH-1:0] ctl_rd_length,
    output logic [ADDRESSWIDTH-1:0] ctl_wr_addr_base,
    output logic [ADDRESSWIDTH-1:0] ctl_wr_length,
    output logic                    ctl_rd_go,
    output logic                    ctl_wr_go,
    input  logic                    ctl_rd_done,
    input  logic                    ctl_wr_done,
    output logic                    usr_rd_buffer,
    input  logic [DATAWIDTH-1:0]    usr_rd_buffer_data,
    input  logic                    usr_rd_buffer_nonempty,
    output logic                    usr_wr_buffer,
    output logic [DATAWIDTH-1:0]    usr_wr_buffer_data,
    input  logic                    usr_wr_buffer_full
);

    localparam logic [ADDRESSWIDTH-1:0] CHUNK = ADDRESSWIDTH'(CHUNK_BYTES);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        GO        = 3'd1,
        XFER      = 3'd2,
        WAIT_DONE = 3'd3,
        FINISH    = 3'd4,
        FAIL      = 3'd5
    } state_t;

    state_t state, state_nxt;

    logic [ADDRESSWIDTH-1:0] src_q, dst_q, rem_q, word_cnt;
    logic [ADDRESSWIDTH-1:0] chunk_len, chunk_words;
    logic                    rd_seen, wr_seen, post_go;
    logic                    length_ok, move, last_word, both_seen;

    function automatic logic [ADDRESSWIDTH-1:0] clamp_chunk(input logic [ADDRESSWIDTH-1:0] rem);
        return (rem > CHUNK) ? CHUNK : rem;
    endfunction

    // Chunk geometry derives from the remaining count, so it stays fixed until WAIT_DONE exits
    assign chunk_len   = clamp_chunk(rem_q);
    assign chunk_words = chunk_len >> 2;
    assign length_ok   = (length != '0) && (length[1:0] == 2'b00);
    assign move        = (state == XFER) && usr_rd_buffer_nonempty && !usr_wr_buffer_full;
    assign last_word   = move && ((word_cnt + ADDRESSWIDTH'(1)) == chunk_words);
    assign both_seen   = rd_seen && wr_seen;

    assign ctl_rd_fixed_location = 1'b0;
    assign ctl_wr_fixed_location = 1'b0;
    assign ctl_rd_addr_base      = src_q;
    assign ctl_wr_addr_base      = dst_q;
    assign ctl_rd_length         = chunk_len;
    assign ctl_wr_length         = chunk_len;
    assign usr_rd_buffer         = move;
    assign usr_wr_buffer         = move;
    assign usr_wr_buffer_data    = move ? usr_rd_buffer_data : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b1;
        done      = 1'b0;
        error     = 1'b0;
        ctl_rd_go = 1'b0;
        ctl_wr_go = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_nxt = length_ok ? GO : FAIL;
                end
            end
            GO: begin
                ctl_rd_go = 1'b1;
                ctl_wr_go = 1'b1;
                state_nxt = XFER;
            end
            XFER: begin
                if (last_word) begin
                    state_nxt = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (both_seen) begin
                    state_nxt = (rem_q == chunk_len) ? FINISH : GO;
                end
            end
            FINISH: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            FAIL: begin
                busy      = 1'b0;
                error     = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                busy      = 1'b0;
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            src_q        <= '0;
            dst_q        <= '0;
            rem_q        <= '0;
            word_cnt     <= '0;
            words_copied <= '0;
            rd_seen      <= 1'b0;
            wr_seen      <= 1'b0;
            post_go      <= 1'b0;
        end else begin
            post_go <= (state == GO);
            case (state)
                IDLE: begin
                    if (start && length_ok) begin
                        src_q        <= src_addr;
                        dst_q        <= dst_addr;
                        rem_q        <= length;
                        words_copied <= '0;
                    end
                end
                GO: begin
                    word_cnt <= '0;
                    rd_seen  <= 1'b0;
                    wr_seen  <= 1'b0;
                end
                XFER: begin
                    if (move) begin
                        word_cnt     <= word_cnt + ADDRESSWIDTH'(1);
                        words_copied <= words_copied + ADDRESSWIDTH'(1);
                    end
                end
                WAIT_DONE: begin
                    if (both_seen) begin
                        src_q <= src_q + chunk_len;
                        dst_q <= dst_q + chunk_len;
                        rem_q <= rem_q - chunk_len;
                    end
                end
                default: begin
                end
            endcase
            // Master done levels are stale until the go has propagated, so skip GO and the cycle after
            if ((state == XFER || state == WAIT_DONE) && !post_go) begin
                if (ctl_rd_done) rd_seen <= 1'b1;
                if (ctl_wr_done) wr_seen <= 1'b1;
            end
        end
    end

endmodule
